hazard_flush_ctrl: RTL and testbench

// - Control-side producer for the IF/ID and ID/EX pipeline registers: generates stall enables, bubble insert and flush (PCSrc-style) strobes.
// - Detects load-use hazards in ID against the load in EX. Stretches stalls for multi-cycle data memory.
// - Converts a taken branch resolved in MEM into a multi-cycle flush of the younger stages.
// - Sits between the EX/MEM branch outcome and the front-end register enables.

---
 rtl/hazard_flush_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl
// Front-end hazard controller for a five-stage pipeline. It stalls PC and IF/ID
// and inserts a bubble on a load-use hazard, and it flushes the younger stages
// for a taken branch resolved in MEM. Both actions can be held for several cycles.
// A taken branch always has priority over a load-use stall.
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// stall_count / flush_count performance counters.

module hazard_flush_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             exmem_taken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             ctrl_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    // Counter reload values. The first cycle of a stall or flush is spent in RUN,
    // so the multi-cycle state only has to cover the remaining N-1 cycles.
    localparam logic [3:0] STALL_RELOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;
    logic       load_use;

    // A load in EX feeding either source of the instruction in ID; x0 is never a hazard.
    assign load_use = idex_MemRead && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    assign busy = (state != RUN);

    // State and hold counter; reset returns to RUN immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state and strobes; a taken branch overrides everything except reset.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        ctrl_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;

        if (!reset) begin
            next_state = RUN;
            next_cnt   = 4'd0;
        end else if (exmem_taken) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = FLUSH;
                next_cnt   = FLUSH_RELOAD;
            end else begin
                next_state = RUN;
                next_cnt   = 4'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        ctrl_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            next_state = STALL;
                            next_cnt   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    ctrl_bubble = 1'b1;
                    if (cnt == 4'd0) begin
                        next_state = RUN;
                    end else begin
                        next_cnt = cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    if (cnt == 4'd0) begin
                        next_state = RUN;
                    end else begin
                        next_cnt = cnt - 4'd1;
                    end
                end
                default: begin
                    next_state = RUN;
                    next_cnt   = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Count bubble and flush cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (ctrl_bubble && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_idex && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl
// Three controller instances with different stall/flush lengths share one input
// stream. A behavioural model tracks "cycles of flush/stall still owed" per
// instance and is compared against every instance each cycle. Directed literal
// checks pin the model on the reset, load-use, x0, branch and collision cases.
// Perf counters are checked when HAZARD_PERF_CNT_EN is defined.

module tb_hazard_flush_ctrl;

    localparam int N = 3;
    localparam int S_LEN[N] = '{1, 3, 1};
    localparam int F_LEN[N] = '{3, 3, 2};

    logic       clk;
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       tk;

    logic pcw[N];
    logic ifw[N];
    logic bub[N];
    logic fif[N];
    logic fid[N];
    logic fex[N];
    logic bsy[N];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] scnt[N];
    logic [31:0] fcnt[N];
`endif

    int testsRun;
    int failCount;

    int stallLeft[N];
    int flushLeft[N];
    int stallTotal[N];
    int flushTotal[N];

    // Three instances: (S=1,F=3), (S=3,F=3), (S=1,F=2).
    hazard_flush_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(32)) dut0 (
        .clk(clk), .reset(rst), .idex_MemRead(mr), .idex_rd(rd), .ifid_rs1(rs1),
        .ifid_rs2(rs2), .exmem_taken(tk), .PCWrite(pcw[0]), .IFIDWrite(ifw[0]),
        .ctrl_bubble(bub[0]), .flush_ifid(fif[0]), .flush_idex(fid[0]),
        .flush_exmem(fex[0]), .busy(bsy[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(scnt[0]), .flush_count(fcnt[0])
`endif
    );

    hazard_flush_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(32)) dut1 (
        .clk(clk), .reset(rst), .idex_MemRead(mr), .idex_rd(rd), .ifid_rs1(rs1),
        .ifid_rs2(rs2), .exmem_taken(tk), .PCWrite(pcw[1]), .IFIDWrite(ifw[1]),
        .ctrl_bubble(bub[1]), .flush_ifid(fif[1]), .flush_idex(fid[1]),
        .flush_exmem(fex[1]), .busy(bsy[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(scnt[1]), .flush_count(fcnt[1])
`endif
    );

    hazard_flush_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut2 (
        .clk(clk), .reset(rst), .idex_MemRead(mr), .idex_rd(rd), .ifid_rs1(rs1),
        .ifid_rs2(rs2), .exmem_taken(tk), .PCWrite(pcw[2]), .IFIDWrite(ifw[2]),
        .ctrl_bubble(bub[2]), .flush_ifid(fif[2]), .flush_idex(fid[2]),
        .flush_exmem(fex[2]), .busy(bsy[2])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(scnt[2]), .flush_count(fcnt[2])
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d @%0t: got %b expected %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int idx, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d @%0t: got %0d expected %0d", name, idx, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            stallLeft[i]  = 0;
            flushLeft[i]  = 0;
            stallTotal[i] = 0;
            flushTotal[i] = 0;
        end
    endtask

    // Compare every instance against the model, then advance the model by one cycle.
    task automatic checkOutput();
        logic lu;
        logic expFlush;
        logic expStall;
        logic expBusy;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        for (int i = 0; i < N; i++) begin
            expBusy  = (flushLeft[i] > 0) || (stallLeft[i] > 0);
            expFlush = tk || (flushLeft[i] > 0);
            expStall = !expFlush && ((stallLeft[i] > 0) || lu);
            check("PCWrite", i, pcw[i], !expStall);
            check("IFIDWrite", i, ifw[i], !expStall);
            check("ctrl_bubble", i, bub[i], expStall);
            check("flush_ifid", i, fif[i], expFlush);
            check("flush_idex", i, fid[i], expFlush);
            check("flush_exmem", i, fex[i], expFlush);
            check("busy", i, bsy[i], expBusy);
`ifdef HAZARD_PERF_CNT_EN
            checkCount("stall_count", i, int'(scnt[i]), stallTotal[i]);
            checkCount("flush_count", i, int'(fcnt[i]), flushTotal[i]);
`endif
            stallTotal[i] += int'(expStall);
            flushTotal[i] += int'(expFlush);
            if (tk) begin
                flushLeft[i] = F_LEN[i] - 1;
                stallLeft[i] = 0;
            end else if (flushLeft[i] > 0) begin
                flushLeft[i]--;
            end else if (stallLeft[i] > 0) begin
                stallLeft[i]--;
            end else if (lu) begin
                stallLeft[i] = S_LEN[i] - 1;
            end
        end
    endtask

    // One clock cycle: drive just after the edge, check mid-cycle.
    task automatic applyStimulus(input logic m, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic t);
        @(posedge clk);
        #1;
        mr  = m;
        rd  = d;
        rs1 = s1;
        rs2 = s2;
        tk  = t;
        #3;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        end
    endtask

    // Directed cases followed by a randomized run.
    initial begin
        testsRun  = 0;
        failCount = 0;
        rst = 1'b0;
        mr  = 1'b0;
        rd  = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        tk  = 1'b0;
        modelReset();
        #3;
        checkOutput();
        #9 rst = 1'b1;

        // Async reset mid-cycle with a taken branch still asserted.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check("lit_branch_flush", 0, fid[0], 1'b1);
        @(posedge clk);
        #1 tk = 1'b1;
        #1 rst = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_PCWrite", i, pcw[i], 1'b1);
            check("rst_IFIDWrite", i, ifw[i], 1'b1);
            check("rst_bubble", i, bub[i], 1'b0);
            check("rst_flush_ifid", i, fif[i], 1'b0);
            check("rst_flush_idex", i, fid[i], 1'b0);
            check("rst_flush_exmem", i, fex[i], 1'b0);
            check("rst_busy", i, bsy[i], 1'b0);
        end
        #1;
        tk  = 1'b0;
        rst = 1'b1;

        // Load-use with a one-cycle stall: exactly one bubble, then RUN.
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
        check("lit_lu_PCWrite", 0, pcw[0], 1'b0);
        check("lit_lu_bubble", 0, bub[0], 1'b1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("lit_lu_after_PCWrite", 0, pcw[0], 1'b1);
        check("lit_lu_after_bubble", 0, bub[0], 1'b0);
        check("lit_lu_after_busy", 0, bsy[0], 1'b0);
        applyStimulus(1'b1, 5'd6, 5'd6, 5'd0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        idle(3);
`ifdef HAZARD_PERF_CNT_EN
        checkCount("lit_perf_stall", 2, int'(scnt[2]), 2);
        checkCount("lit_perf_flush", 2, int'(fcnt[2]), 2);
`endif
        idle(1);

        // x0 destination and non-matching registers never stall.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        check("lit_x0_PCWrite", 0, pcw[0], 1'b1);
        check("lit_x0_bubble", 0, bub[0], 1'b0);
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd4, 1'b0);
        check("lit_nomatch_PCWrite", 0, pcw[0], 1'b1);
        check("lit_nomatch_bubble", 0, bub[0], 1'b0);

        // One-cycle branch pulse with a three-cycle flush.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check("lit_br0_flush", 0, fid[0], 1'b1);
        check("lit_br0_busy", 0, bsy[0], 1'b0);
        idle(1);
        check("lit_br1_flush", 0, fid[0], 1'b1);
        check("lit_br1_busy", 0, bsy[0], 1'b1);
        idle(1);
        check("lit_br2_flush", 0, fid[0], 1'b1);
        check("lit_br2_busy", 0, bsy[0], 1'b1);
        idle(1);
        check("lit_br3_flush", 0, fid[0], 1'b0);
        check("lit_br3_busy", 0, bsy[0], 1'b0);

        // Branch in the second cycle of a three-cycle stall aborts it.
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        check("lit_col0_PCWrite", 1, pcw[1], 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check("lit_col1_PCWrite", 1, pcw[1], 1'b1);
        check("lit_col1_bubble", 1, bub[1], 1'b0);
        check("lit_col1_flush", 1, fid[1], 1'b1);
        idle(4);

        // Randomized traffic over a small register set so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 6) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
